// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: decode-side hazard and forwarding controller for a 5-stage
// MIPS pipeline. It keeps a shadow copy of the EX/MEM/WB destination info and
// drives the load-use stall, the EX operand forwarding selects and a saturating
// stall-cycle counter.
// Build option HAZARD_FORWARDING_EN: when defined, EX/MEM and WB results are
// forwarded and only load-use hazards stall. When undefined, the forwarding
// selects are tied to the register file and every RAW dependency on an EX or
// MEM producer stalls until that producer reaches WB.
module hazard_fwd_unit #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0]       SEL_RF   = 2'b00;
    localparam logic [RA_W-1:0]  REG_ZERO = {RA_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Shadow pipeline stages
    logic            r_ex_valid;
    logic [RA_W-1:0] r_ex_dst;
    logic            r_ex_regwrite;
    logic            r_ex_memread;
    logic            r_mem_valid;
    logic [RA_W-1:0] r_mem_dst;
    logic            r_mem_regwrite;
    logic            r_mem_memread;
    logic            r_wb_valid;
    logic [RA_W-1:0] r_wb_dst;
    logic            r_wb_regwrite;
    logic            r_wb_memread;

    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_eff;
    logic w_mem_eff;
    logic w_rs_hit_ex;
    logic w_rt_hit_ex;
    logic w_rs_hit_mem;
    logic w_rt_hit_mem;
    logic w_stall;
    logic w_bubble;

    // Register $0 is hard-wired to zero, so a write to it is never a producer.
    assign w_ex_eff  = r_ex_valid  & r_ex_regwrite  & (r_ex_dst  != REG_ZERO);
    assign w_mem_eff = r_mem_valid & r_mem_regwrite & (r_mem_dst != REG_ZERO);

    assign w_rs_hit_ex  = id_use_rs & w_ex_eff  & (id_rs == r_ex_dst);
    assign w_rt_hit_ex  = id_use_rt & w_ex_eff  & (id_rt == r_ex_dst);
    assign w_rs_hit_mem = id_use_rs & w_mem_eff & (id_rs == r_mem_dst);
    assign w_rt_hit_mem = id_use_rt & w_mem_eff & (id_rt == r_mem_dst);

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time: its data exists after MEM.
    assign w_stall = id_valid & ~flush & r_ex_memread & (w_rs_hit_ex | w_rt_hit_ex);
`else
    // No bypass paths: wait until the producer has reached WB.
    assign w_stall = id_valid & ~flush &
                     (w_rs_hit_ex | w_rt_hit_ex | w_rs_hit_mem | w_rt_hit_mem);
`endif

    // A flushed, stalled or empty ID slot enters EX as a bubble.
    assign w_bubble = w_stall | flush | ~id_valid;
    assign stall    = w_stall;
    assign stall_cnt = r_stall_cnt;

    // Advance the shadow pipe; ID enters EX unless a bubble is injected
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_dst       <= REG_ZERO;
            r_ex_regwrite  <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_dst      <= REG_ZERO;
            r_mem_regwrite <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_dst       <= REG_ZERO;
            r_wb_regwrite  <= 1'b0;
            r_wb_memread   <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_dst       <= r_mem_dst;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memread   <= r_mem_memread;
            r_mem_valid    <= r_ex_valid;
            r_mem_dst      <= r_ex_dst;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_memread  <= r_ex_memread;
            if (w_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_dst      <= REG_ZERO;
                r_ex_regwrite <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_valid    <= id_valid;
                r_ex_dst      <= id_dst;
                r_ex_regwrite <= id_regwrite;
                r_ex_memread  <= id_memread;
            end
        end
    end

    // Count stall cycles, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= CNT_ZERO;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_WB    = 2'b10;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    // Pick the forwarding source for each ID operand; the younger producer wins
    always_comb begin
        w_fwd_a = SEL_RF;
        w_fwd_b = SEL_RF;
        if (w_rs_hit_ex) begin
            w_fwd_a = SEL_EXMEM;
        end else if (w_rs_hit_mem) begin
            w_fwd_a = SEL_WB;
        end else begin
            w_fwd_a = SEL_RF;
        end
        if (w_rt_hit_ex) begin
            w_fwd_b = SEL_EXMEM;
        end else if (w_rt_hit_mem) begin
            w_fwd_b = SEL_WB;
        end else begin
            w_fwd_b = SEL_RF;
        end
    end

    // Register the selects as the instruction enters EX; bubbles read the regfile
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_a <= SEL_RF;
            r_fwd_b <= SEL_RF;
        end else if (w_bubble) begin
            r_fwd_a <= SEL_RF;
            r_fwd_b <= SEL_RF;
        end else begin
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
`else
    assign fwd_a_sel = SEL_RF;
    assign fwd_b_sel = SEL_RF;
`endif

    // The WB copy is kept for visibility only; the regfile's write-then-read
    // timing means a WB producer never needs forwarding or a stall.
    logic w_unused;
    assign w_unused = &{1'b0, r_wb_valid, r_wb_dst, r_wb_regwrite, r_wb_memread};

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scoreboard bench for hazard_fwd_unit. Each issued ID
// cycle pushes the expected {stall, fwd_a, fwd_b, stall_cnt} computed from an
// instruction-history model; a monitor pops and compares on the falling edge.
module tb_hazard_fwd_unit;

    localparam int RA_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             id_valid = 1'b0;
    logic [RA_W-1:0]  id_rs = 5'd0;
    logic [RA_W-1:0]  id_rt = 5'd0;
    logic             id_use_rs = 1'b0;
    logic             id_use_rt = 1'b0;
    logic [RA_W-1:0]  id_dst = 5'd0;
    logic             id_regwrite = 1'b0;
    logic             id_memread = 1'b0;
    logic             flush = 1'b0;
    logic             stall;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
        bit       fl;
    } id_t;

    // One instruction (or bubble) as it entered EX
    typedef struct {
        bit       v;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
    } prod_t;

    typedef struct {
        bit             st;
        bit [1:0]       a;
        bit [1:0]       b;
        bit [CNT_W-1:0] cnt;
        int             seq;
    } exp_t;

    prod_t    hist[$];   // instructions in the order they entered EX
    exp_t     sb[$];
    bit [1:0] m_sel_a;
    bit [1:0] m_sel_b;
    int       m_cnt;
    int       seq = 0;
    int       checks = 0;
    int       errors = 0;

    function automatic id_t mk_alu(input bit [4:0] d, input bit [4:0] s, input bit [4:0] t);
        id_t x;
        x.v = 1'b1; x.rs = s; x.rt = t; x.urs = 1'b1; x.urt = 1'b1;
        x.dst = d; x.rw = 1'b1; x.mr = 1'b0; x.fl = 1'b0;
        return x;
    endfunction

    function automatic id_t mk_lw(input bit [4:0] d, input bit [4:0] base);
        id_t x;
        x = mk_alu(d, base, 5'd0);
        x.urt = 1'b0; x.mr = 1'b1;
        return x;
    endfunction

    function automatic id_t mk_nop();
        id_t x;
        x = mk_alu(5'd0, 5'd0, 5'd0);
        x.urs = 1'b0; x.urt = 1'b0; x.rw = 1'b0;
        return x;
    endfunction

    function automatic bit writes(input prod_t p);
        return p.v && p.rw && (p.dst != 5'd0);
    endfunction

    function automatic bit reads_from(input bit used, input bit [4:0] r, input prod_t p);
        return used && writes(p) && (r == p.dst);
    endfunction

    function automatic bit [1:0] pick(input bit used, input bit [4:0] r,
                                      input prod_t ex, input prod_t mem);
        if (reads_from(used, r, ex))  return 2'b01;
        if (reads_from(used, r, mem)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        prod_t b;
        b.v = 1'b0; b.dst = 5'd0; b.rw = 1'b0; b.mr = 1'b0;
        hist.delete();
        hist.push_back(b);
        hist.push_back(b);
        m_sel_a = 2'b00;
        m_sel_b = 2'b00;
        m_cnt   = 0;
    endtask

    task automatic apply(input id_t x);
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_use_rs = x.urs; id_use_rt = x.urt;
        id_dst = x.dst; id_regwrite = x.rw; id_memread = x.mr; flush = x.fl;
    endtask

    // Drive one ID cycle (entered at posedge+1), queue its expectation, advance the model
    task automatic step(input id_t x, output bit st);
        prod_t    ex;
        prod_t    mem;
        prod_t    ent;
        exp_t     e;
        bit       bub;
        bit [1:0] na;
        bit [1:0] nb;
        apply(x);
        ex  = hist[hist.size()-1];
        mem = hist[hist.size()-2];
`ifdef HAZARD_FORWARDING_EN
        st = x.v && !x.fl && ex.mr &&
             (reads_from(x.urs, x.rs, ex) || reads_from(x.urt, x.rt, ex));
        na = pick(x.urs, x.rs, ex, mem);
        nb = pick(x.urt, x.rt, ex, mem);
`else
        st = x.v && !x.fl &&
             (reads_from(x.urs, x.rs, ex) || reads_from(x.urt, x.rt, ex) ||
              reads_from(x.urs, x.rs, mem) || reads_from(x.urt, x.rt, mem));
        na = 2'b00;
        nb = 2'b00;
`endif
        bub = st || x.fl || !x.v;
        e.st = st; e.a = m_sel_a; e.b = m_sel_b; e.cnt = CNT_W'(m_cnt); e.seq = seq;
        sb.push_back(e);
        seq++;
        @(posedge clk);
        ent.v = x.v && !bub; ent.dst = bub ? 5'd0 : x.dst;
        ent.rw = !bub && x.rw; ent.mr = !bub && x.mr;
        hist.push_back(ent);
        if (hist.size() > 4) void'(hist.pop_front());
        m_sel_a = bub ? 2'b00 : na;
        m_sel_b = bub ? 2'b00 : nb;
        if (st && m_cnt < CNT_MAX) m_cnt++;
        #1;
    endtask

    // Issue an instruction, holding it in ID for as long as it is stalled
    task automatic issue(input id_t x);
        bit st;
        int n;
        n = 0;
        do begin
            step(x, st);
            n++;
        end while (st && n < 4);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(mk_nop());
    endtask

    // Assert reset between edges: outputs must clear before any clock edge
    task automatic reset_now();
        exp_t e;
        rst = 1'b0;
        #1;
        e.st = 1'b0; e.a = 2'b00; e.b = 2'b00; e.cnt = {CNT_W{1'b0}}; e.seq = seq;
        sb.push_back(e);
        seq++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
    endtask

    task automatic check_cnt(input int exp_v, input int tag);
        checks++;
        if (stall_cnt !== CNT_W'(exp_v)) begin
            errors++;
            $display("FAIL stall_cnt_%0d: got %0d expected %0d", tag, stall_cnt, exp_v);
        end
    endtask

    // Monitor: compare every presented output cycle against the queued expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (stall !== e.st || fwd_a_sel !== e.a || fwd_b_sel !== e.b || stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL cycle_%0d: got stall=%b fa=%b fb=%b cnt=%0d expected stall=%b fa=%b fb=%b cnt=%0d",
                         e.seq, stall, fwd_a_sel, fwd_b_sel, stall_cnt, e.st, e.a, e.b, e.cnt);
            end
        end
    end

    initial begin
        id_t x;
        int  waited;
        model_clear();
        #1;
        reset_now();

        // EX-stage forward: add $3 ; sub $4,$3,$5
        issue(mk_alu(5'd3, 5'd1, 5'd2));
        issue(mk_alu(5'd4, 5'd3, 5'd5));
        nops(3);
`ifdef HAZARD_FORWARDING_EN
        check_cnt(0, 2);
`else
        check_cnt(2, 2);
`endif

        // WB forward, then younger producer priority
        issue(mk_alu(5'd3, 5'd1, 5'd1));
        issue(mk_nop());
        issue(mk_alu(5'd6, 5'd3, 5'd3));
        nops(2);
        issue(mk_alu(5'd3, 5'd1, 5'd1));
        issue(mk_alu(5'd3, 5'd2, 5'd2));
        issue(mk_alu(5'd7, 5'd3, 5'd0));
        nops(3);

        // Load-use from a clean counter
        reset_now();
        issue(mk_lw(5'd2, 5'd1));
        issue(mk_alu(5'd8, 5'd2, 5'd9));
        nops(2);
`ifdef HAZARD_FORWARDING_EN
        check_cnt(1, 4);
`else
        check_cnt(2, 4);
`endif

        // Writes to $0 never create hazards
        issue(mk_alu(5'd0, 5'd1, 5'd1));
        issue(mk_alu(5'd5, 5'd0, 5'd0));
        issue(mk_lw(5'd0, 5'd1));
        issue(mk_alu(5'd6, 5'd0, 5'd0));
        nops(2);

        // Flush on the dependent of a load: no stall, no count
        issue(mk_lw(5'd2, 5'd1));
        x = mk_alu(5'd8, 5'd2, 5'd9);
        x.fl = 1'b1;
        issue(x);
        nops(3);

        // Reset in the middle of a stall, then no stale forward afterwards
        issue(mk_alu(5'd3, 5'd1, 5'd1));
        issue(mk_lw(5'd2, 5'd1));
        apply(mk_alu(5'd8, 5'd2, 5'd3));
        reset_now();
        issue(mk_alu(5'd8, 5'd2, 5'd3));
        nops(2);
        check_cnt(0, 7);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            bit st;
            x.v   = ($urandom_range(0, 7) != 0);
            x.rs  = 5'($urandom_range(0, 3));
            x.rt  = 5'($urandom_range(0, 3));
            x.urs = 1'($urandom_range(0, 1));
            x.urt = 1'($urandom_range(0, 1));
            x.dst = 5'($urandom_range(0, 3));
            x.rw  = ($urandom_range(0, 3) != 0);
            x.mr  = ($urandom_range(0, 2) == 0);
            x.fl  = ($urandom_range(0, 7) == 0);
            step(x, st);
        end

        // Saturation at the top of the counter
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            issue(mk_lw(5'd2, 5'd1));
            issue(mk_alu(5'd8, 5'd2, 5'd2));
        end
        nops(2);
        check_cnt(CNT_MAX, 9);

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
